nco_sweep_ctrl: RTL and testbench

Phase-accumulator controller that sequences the 256-entry sin/cos lookup table in the IQ modulator. It generates the 8-bit sin and cos table addresses every clock, in one of two modes: fixed-tone or linear frequency sweep (chirp). A programmable quadrature phase offset is applied on the cos address for I/Q phase-imbalance trim. Configuration is loaded through a valid/ready handshake and then armed for start/stop control.

---
 rtl/nco_sweep_ctrl.sv | 142 ++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl.sv
// Phase-accumulator controller for the 256-entry sin/cos lookup table.
// Produces sin/cos table addresses in fixed-tone or linear-sweep (chirp) mode,
// with a programmable cos-address offset for I/Q phase-imbalance trim.
module nco_sweep_ctrl #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ACC_W-1:0] cfg_ftw,
  input  logic [ACC_W-1:0] cfg_step,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [7:0]       cfg_qoff,
  input  logic             cfg_mode,
  input  logic             start,
  input  logic             stop,
  output logic [7:0]       sval,
  output logic [7:0]       cval,
  output logic             sample_stb,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StArmed, StRun, StSweep} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] ftw_cur_q, ftw_cur_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] ftw_reg_q, ftw_reg_d;
  logic [ACC_W-1:0] step_reg_q, step_reg_d;
  logic [CNT_W-1:0] count_reg_q, count_reg_d;
  logic [7:0]       qoff_reg_q, qoff_reg_d;
  logic             mode_reg_q, mode_reg_d;
  logic             done_q, done_d;
  logic             cfg_fire;

  assign cfg_ready  = (state_q == StIdle) || (state_q == StArmed);
  assign cfg_fire   = cfg_valid && cfg_ready;
  assign busy       = (state_q == StRun) || (state_q == StSweep);
  assign sample_stb = busy;
  assign done       = done_q;
  assign sval       = acc_q[ACC_W-1 -: 8];
  assign cval       = sval + qoff_reg_q;

  // Next-state logic: config handshake first, then start/stop and accumulation.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ftw_cur_d   = ftw_cur_q;
    cnt_d       = cnt_q;
    ftw_reg_d   = ftw_reg_q;
    step_reg_d  = step_reg_q;
    count_reg_d = count_reg_q;
    qoff_reg_d  = qoff_reg_q;
    mode_reg_d  = mode_reg_q;
    done_d      = 1'b0;

    if (cfg_fire) begin
      // A handshake in ARMED wins over a same-cycle start.
      ftw_reg_d   = cfg_ftw;
      step_reg_d  = cfg_step;
      count_reg_d = cfg_count;
      qoff_reg_d  = cfg_qoff;
      mode_reg_d  = cfg_mode;
      state_d     = StArmed;
    end else begin
      unique case (state_q)
        StIdle: ;
        StArmed: begin
          if (start && !stop) begin
            acc_d     = '0;
            ftw_cur_d = ftw_reg_q;
            cnt_d     = count_reg_q;
            if (!mode_reg_q) begin
              state_d = StRun;
            end else if (count_reg_q == '0) begin
              // Empty sweep: report completion without generating samples.
              done_d = 1'b1;
            end else begin
              state_d = StSweep;
            end
          end
        end
        StRun: begin
          if (stop) begin
            state_d = StArmed;
            acc_d   = '0;
          end else begin
            acc_d = acc_q + ftw_cur_q;
          end
        end
        StSweep: begin
          if (stop) begin
            state_d = StArmed;
            acc_d   = '0;
          end else if (cnt_q == CNT_W'(1)) begin
            state_d = StArmed;
            acc_d   = '0;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            acc_d     = acc_q + ftw_cur_q;
            ftw_cur_d = ftw_cur_q + step_reg_q;
            cnt_d     = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      ftw_cur_q   <= '0;
      cnt_q       <= '0;
      ftw_reg_q   <= '0;
      step_reg_q  <= '0;
      count_reg_q <= '0;
      qoff_reg_q  <= '0;
      mode_reg_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ftw_cur_q   <= ftw_cur_d;
      cnt_q       <= cnt_d;
      ftw_reg_q   <= ftw_reg_d;
      step_reg_q  <= step_reg_d;
      count_reg_q <= count_reg_d;
      qoff_reg_q  <= qoff_reg_d;
      mode_reg_q  <= mode_reg_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: directed literal checks followed by
// randomized traffic compared every cycle against a closed-form phase model.
module tb_nco_sweep_ctrl;

  localparam int unsigned ACC_W = 24;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [ACC_W-1:0] cfg_ftw;
  logic [ACC_W-1:0] cfg_step;
  logic [CNT_W-1:0] cfg_count;
  logic [7:0]       cfg_qoff;
  logic             cfg_mode;
  logic             start;
  logic             stop;
  logic [7:0]       sval;
  logic [7:0]       cval;
  logic             sample_stb;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: loaded config, whether generating, and sample index.
  bit               m_have_cfg;
  bit               m_gen;
  bit               m_sweep;
  bit               m_done;
  longint unsigned  m_n;
  longint unsigned  c_ftw, c_step, c_count;
  logic [7:0]       c_qoff;
  bit               c_mode;

  logic [7:0] exp_sw [4] = '{8'h00, 8'h00, 8'h01, 8'h03};

  nco_sweep_ctrl #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ftw    (cfg_ftw),
    .cfg_step   (cfg_step),
    .cfg_count  (cfg_count),
    .cfg_qoff   (cfg_qoff),
    .cfg_mode   (cfg_mode),
    .start      (start),
    .stop       (stop),
    .sval       (sval),
    .cval       (cval),
    .sample_stb (sample_stb),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Phase of sample n: n*ftw plus, in a chirp, step*n*(n-1)/2, modulo 2^24.
  function automatic logic [7:0] exp_sval();
    longint unsigned p;
    if (!m_gen) return 8'h00;
    p = m_n * c_ftw;
    if (m_sweep) p += c_step * ((m_n * (m_n - 1)) / 2);
    return p[23:16];
  endfunction

  task automatic compare();
    logic [7:0] es;
    es = exp_sval();
    chk("sval", 32'(sval), 32'(es));
    chk("cval", 32'(cval), 32'(8'(es + c_qoff)));
    chk("sample_stb", 32'(sample_stb), 32'(m_gen));
    chk("busy", 32'(busy), 32'(m_gen));
    chk("cfg_ready", 32'(cfg_ready), 32'(!m_gen));
    chk("done", 32'(done), 32'(m_done));
  endtask

  // Apply one clock edge's worth of input effects to the model.
  task automatic model_advance();
    bit nd;
    if (rst) begin
      m_have_cfg = 0; m_gen = 0; m_sweep = 0; m_done = 0; m_n = 0;
      c_ftw = 0; c_step = 0; c_count = 0; c_qoff = 0; c_mode = 0;
      return;
    end
    nd = 0;
    if (m_gen) begin
      if (stop) begin
        m_gen = 0;
      end else begin
        m_n++;
        if (m_sweep && m_n == c_count) begin
          m_gen = 0;
          nd    = 1;
        end
      end
    end else if (cfg_valid) begin
      c_ftw = cfg_ftw; c_step = cfg_step; c_count = cfg_count;
      c_qoff = cfg_qoff; c_mode = cfg_mode;
      m_have_cfg = 1;
    end else if (m_have_cfg && start && !stop) begin
      if (c_mode && c_count == 0) begin
        nd = 1;
      end else begin
        m_gen   = 1;
        m_sweep = c_mode;
        m_n     = 0;
      end
    end
    m_done = nd;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_advance();
    @(negedge clk);
    compare();
  endtask

  task automatic load_cfg(input logic [23:0] ftw, input logic [23:0] stp,
                          input logic [15:0] cnt, input logic [7:0] qoff, input logic mode);
    cfg_ftw = ftw; cfg_step = stp; cfg_count = cnt; cfg_qoff = qoff; cfg_mode = mode;
    cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_ftw = '0; cfg_step = '0; cfg_count = '0;
    cfg_qoff = '0; cfg_mode = 1'b0; start = 1'b0; stop = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sval", 32'(sval), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Fixed tone, one address step per sample, cos offset 0x40.
    load_cfg(24'h010000, 24'h0, 16'd0, 8'h40, 1'b0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("tone_s0", 32'(sval), 32'h00);
    chk("tone_c0", 32'(cval), 32'h40);
    chk("tone_busy", 32'(busy), 32'd1);
    chk("tone_ready", 32'(cfg_ready), 32'd0);
    cyc();
    chk("tone_s1", 32'(sval), 32'h01);
    chk("tone_c1", 32'(cval), 32'h41);
    for (int i = 0; i < 255; i++) cyc();
    chk("tone_wrap", 32'(sval), 32'h00);

    // Stop, then restart from zero.
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_stb", 32'(sample_stb), 32'd0);
    chk("stop_sval", 32'(sval), 32'd0);
    chk("stop_cval", 32'(cval), 32'h40);
    chk("stop_done", 32'(done), 32'd0);
    chk("stop_ready", 32'(cfg_ready), 32'd1);
    start = 1'b1; cyc(); start = 1'b0;
    chk("restart_s0", 32'(sval), 32'h00);
    cyc();
    chk("restart_s1", 32'(sval), 32'h01);
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    chk("startstop_busy", 32'(busy), 32'd0);
    cyc();
    chk("startstop_busy2", 32'(busy), 32'd0);

    // Config + start together: config latched, no generation.
    cfg_ftw = 24'h0; cfg_step = 24'h010000; cfg_count = 16'd4; cfg_qoff = 8'h00;
    cfg_mode = 1'b1; cfg_valid = 1'b1; start = 1'b1;
    cyc();
    cfg_valid = 1'b0; start = 1'b0;
    chk("cfgstart_busy", 32'(busy), 32'd0);
    cyc();
    chk("cfgstart_busy2", 32'(busy), 32'd0);

    // Four-sample chirp.
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("sweep_sval", 32'(sval), 32'(exp_sw[i]));
      chk("sweep_stb", 32'(sample_stb), 32'd1);
      cyc();
    end
    chk("sweep_done", 32'(done), 32'd1);
    chk("sweep_end_stb", 32'(sample_stb), 32'd0);
    chk("sweep_end_ready", 32'(cfg_ready), 32'd1);
    cyc();
    chk("sweep_done_clr", 32'(done), 32'd0);

    // Zero-length sweep.
    load_cfg(24'h123456, 24'h1, 16'd0, 8'h10, 1'b1);
    start = 1'b1; cyc(); start = 1'b0;
    chk("cnt0_done", 32'(done), 32'd1);
    chk("cnt0_stb", 32'(sample_stb), 32'd0);
    cyc();
    chk("cnt0_done_clr", 32'(done), 32'd0);

    // Reset during a sweep at count 2, then start ignored until configured.
    load_cfg(24'h020000, 24'h000100, 16'd4, 8'h22, 1'b1);
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("midrst_sval", 32'(sval), 32'd0);
    chk("midrst_cval", 32'(cval), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(cfg_ready), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("idle_start_busy", 32'(busy), 32'd0);
    load_cfg(24'h0, 24'h0, 16'd3, 8'h0, 1'b0);
    chk("idle_cfg_busy", 32'(busy), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 5000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      start     = ($urandom_range(0, 3) == 0);
      stop      = ($urandom_range(0, 29) == 0);
      cfg_ftw   = 24'($urandom);
      cfg_step  = 24'($urandom);
      cfg_count = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
      cfg_qoff  = 8'($urandom);
      cfg_mode  = 1'($urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
